// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared constants and fetch state type for the 8-bit processor
package processor_pkg;

    localparam int ADDR_W = 6;
    localparam int PC_W   = 3;
    localparam int DATA_W = 8;

    // Unmapped instruction memory reads as zero, so running off the program halts.
    localparam logic [DATA_W-1:0] HALT_OPCODE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_DATA,
        FETCH_OPCODE,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: operand/opcode pair fetch, issue, jump and halt
module fetch_ctrl
    import processor_pkg::*;
#(
    parameter int                 ADDR_W      = processor_pkg::ADDR_W,
    parameter int                 PC_W        = processor_pkg::PC_W,
    parameter int                 DATA_W      = processor_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = processor_pkg::HALT_OPCODE
) (
    input  logic              fetch_ctrl_clk,
    input  logic              fetch_ctrl_rst,
    input  logic              fetch_ctrl_start,
    input  logic              fetch_ctrl_jump,
    input  logic [ADDR_W-1:0] fetch_ctrl_jump_addr,
    output logic [ADDR_W-1:0] fetch_ctrl_instr_mem_addr,
    input  logic [DATA_W-1:0] fetch_ctrl_instr_mem_data,
    output logic [DATA_W-1:0] fetch_ctrl_operand,
    output logic [DATA_W-1:0] fetch_ctrl_opcode,
    output logic              fetch_ctrl_valid,
    input  logic              fetch_ctrl_ready,
    output logic              fetch_ctrl_halted
);

    localparam int IC_W = ADDR_W - PC_W;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] jump_target;
    logic [PC_W-1:0]   pc;
    logic [IC_W-1:0]   ic;
    logic              jump_active;

    // Instruction-counter carry ripples into the PC; the top wraps silently.
    assign {pc, ic}    = addr;
    assign addr_inc    = {pc + PC_W'(&ic), ic + 1'b1};
    assign jump_target = fetch_ctrl_jump_addr & ~ADDR_W'(1);
    assign jump_active = fetch_ctrl_jump &&
                         (state == FETCH_DATA || state == FETCH_OPCODE || state == ISSUE);

    always_ff @(posedge fetch_ctrl_clk or posedge fetch_ctrl_rst) begin
        if (fetch_ctrl_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (fetch_ctrl_start) state_next = FETCH_DATA;
            FETCH_DATA:   state_next = jump_active ? FETCH_DATA : FETCH_OPCODE;
            FETCH_OPCODE: begin
                if (jump_active)                                   state_next = FETCH_DATA;
                else if (fetch_ctrl_instr_mem_data == HALT_OPCODE) state_next = HALT;
                else                                               state_next = ISSUE;
            end
            ISSUE:        if (jump_active || fetch_ctrl_ready) state_next = FETCH_DATA;
            HALT:         if (fetch_ctrl_start) state_next = FETCH_DATA;
            default:      state_next = IDLE;
        endcase
    end

    always_comb begin
        fetch_ctrl_valid  = 1'b0;
        fetch_ctrl_halted = 1'b0;
        case (state)
            ISSUE:   fetch_ctrl_valid  = 1'b1;
            HALT:    fetch_ctrl_halted = 1'b1;
            default: ;
        endcase
    end

    // A jump discards whatever half of the pair is in flight; issued registers hold.
    always_ff @(posedge fetch_ctrl_clk or posedge fetch_ctrl_rst) begin
        if (fetch_ctrl_rst) begin
            addr               <= '0;
            fetch_ctrl_operand <= '0;
            fetch_ctrl_opcode  <= '0;
        end else begin
            if (jump_active) begin
                addr <= jump_target;
            end else begin
                case (state)
                    FETCH_DATA: begin
                        fetch_ctrl_operand <= fetch_ctrl_instr_mem_data;
                        addr               <= addr_inc;
                    end
                    FETCH_OPCODE: begin
                        fetch_ctrl_opcode <= fetch_ctrl_instr_mem_data;
                        addr              <= addr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fetch_ctrl_instr_mem_addr = addr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a program-walk reference model
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       jump = 1'b0;
    logic [5:0] jump_addr = '0;
    logic [5:0] addr;
    logic [7:0] mem_data;
    logic [7:0] operand;
    logic [7:0] opcode;
    logic       valid;
    logic       ready = 1'b0;
    logic       halted;

    logic [7:0]  mem [64];
    logic [15:0] got_q [$];
    int          got_cyc [$];
    logic [15:0] exp_q [$];
    logic [5:0]  exp_halt;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    fetch_ctrl dut (
        .fetch_ctrl_clk            (clk),
        .fetch_ctrl_rst            (rst),
        .fetch_ctrl_start          (start),
        .fetch_ctrl_jump           (jump),
        .fetch_ctrl_jump_addr      (jump_addr),
        .fetch_ctrl_instr_mem_addr (addr),
        .fetch_ctrl_instr_mem_data (mem_data),
        .fetch_ctrl_operand        (operand),
        .fetch_ctrl_opcode         (opcode),
        .fetch_ctrl_valid          (valid),
        .fetch_ctrl_ready          (ready),
        .fetch_ctrl_halted         (halted)
    );

    assign mem_data = mem[addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            got_q.push_back({opcode, operand});
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_image;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'hCD; mem[1] = 8'h33; mem[2] = 8'h63; mem[3] = 8'h30;
        mem[4] = 8'hFF; mem[5] = 8'h04; mem[6] = 8'hFF; mem[7] = 8'hC0;
    endtask

    // Reference: walk the program two bytes at a time until an opcode of zero.
    task automatic model_walk(input logic [5:0] a0);
        logic [5:0] a;
        a = a0;
        exp_halt = 'x;
        for (int n = 0; n < 40; n++) begin
            if (mem[6'(a + 6'd1)] == 8'h00) begin
                exp_halt = a + 6'd2;
                break;
            end
            exp_q.push_back({mem[6'(a + 6'd1)], mem[a]});
            a = a + 6'd2;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; jump = 1'b0; ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic run_to_halt(input bit rnd_ready);
        for (int n = 0; n < 2000; n++) begin
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick;
            if (halted) break;
        end
        ready = 1'b0;
    endtask

    task automatic test_reset;
        load_image;
        do_reset;
        checks++;
        if (addr !== 6'd0 || valid !== 1'b0 || halted !== 1'b0 || operand !== 8'd0 || opcode !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d valid=%b halted=%b operand=%h opcode=%h, required all zero",
                     addr, valid, halted, operand, opcode);
        end
    endtask

    task automatic test_basic;
        do_reset;
        model_walk(6'd0);
        start = 1'b1; ready = 1'b1;
        tick; start = 1'b0;
        checks++;
        if (valid !== 1'b0 || addr !== 6'd0) begin
            errors++; $display("FAIL basic_fd: valid=%b addr=%0d, required 0/0", valid, addr);
        end
        tick;
        checks++;
        if (valid !== 1'b0 || addr !== 6'd1) begin
            errors++; $display("FAIL basic_fo: valid=%b addr=%0d, required 0/1", valid, addr);
        end
        tick;
        checks++;
        if (valid !== 1'b1 || {opcode, operand} !== 16'h33CD || addr !== 6'd2) begin
            errors++;
            $display("FAIL basic_first_valid: valid=%b pair=%h addr=%0d, required 1/33cd/2", valid, {opcode, operand}, addr);
        end
        run_to_halt(1'b0);
        checks++;
        if (halted !== 1'b1 || addr !== exp_halt) begin
            errors++; $display("FAIL basic_halt: halted=%b addr=%0d, required 1/%0d", halted, addr, exp_halt);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL basic_pair%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[i] - got_cyc[i-1] != 3) begin
                        errors++; $display("FAIL basic_spacing%0d: got %0d cycles, required 3", i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        model_walk(6'd0);
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (valid !== 1'b1 || {opcode, operand} !== 16'h33CD || addr !== 6'd2) begin
                errors++;
                $display("FAIL stall%0d: valid=%b pair=%h addr=%0d, required 1/33cd/2", i, valid, {opcode, operand}, addr);
            end
        end
        run_to_halt(1'b1);
        checks++;
        if (got_q.size() != exp_q.size() || halted !== 1'b1) begin
            errors++; $display("FAIL stall_count: got %0d pairs halted=%b, required %0d/1", got_q.size(), halted, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stall_pair%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_jump_fetch;
        do_reset;
        model_walk(6'd4);
        ready = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        tick;
        jump = 1'b1; jump_addr = 6'd5;
        tick; jump = 1'b0;
        checks++;
        if (addr !== 6'd4 || valid !== 1'b0) begin
            errors++; $display("FAIL jump_fetch_target: addr=%0d valid=%b, required 4/0", addr, valid);
        end
        run_to_halt(1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL jump_fetch_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL jump_fetch_pair%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_jump_issue;
        do_reset;
        exp_q.push_back(16'h33CD);
        model_walk(6'd4);
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        ready = 1'b1; jump = 1'b1; jump_addr = 6'd4;
        tick; jump = 1'b0;
        checks++;
        if (addr !== 6'd4 || valid !== 1'b0) begin
            errors++; $display("FAIL jump_issue_target: addr=%0d valid=%b, required 4/0", addr, valid);
        end
        run_to_halt(1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL jump_issue_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL jump_issue_pair%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_halt_resume;
        mem[10] = 8'h11; mem[11] = 8'h22;
        got_q.delete(); exp_q.delete();
        model_walk(6'd10);
        jump = 1'b1; jump_addr = 6'd0;
        tick; jump = 1'b0;
        checks++;
        if (halted !== 1'b1 || addr !== 6'd10) begin
            errors++; $display("FAIL halt_jump_ignored: halted=%b addr=%0d, required 1/10", halted, addr);
        end
        start = 1'b1; tick; start = 1'b0;
        checks++;
        if (halted !== 1'b0 || addr !== 6'd10) begin
            errors++; $display("FAIL halt_resume: halted=%b addr=%0d, required 0/10", halted, addr);
        end
        run_to_halt(1'b0);
        checks++;
        if (got_q.size() != exp_q.size() || addr !== exp_halt) begin
            errors++;
            $display("FAIL resume_count: got %0d pairs addr=%0d, required %0d/%0d", got_q.size(), addr, exp_q.size(), exp_halt);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL resume_pair%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        load_image;
    endtask

    task automatic test_reset_mid;
        do_reset;
        ready = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        repeat (5) tick;
        ready = 1'b0;
        checks++;
        if (valid !== 1'b1 || {opcode, operand} !== 16'h3063) begin
            errors++; $display("FAIL mid_setup: valid=%b pair=%h, required 1/3063", valid, {opcode, operand});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || addr !== 6'd0 || operand !== 8'd0 || opcode !== 8'd0) begin
            errors++;
            $display("FAIL mid_async: valid=%b addr=%0d operand=%h opcode=%h, required all zero", valid, addr, operand, opcode);
        end
        tick; rst = 1'b0;
        got_q.delete();
        ready = 1'b1;
        repeat (4) tick;
        checks++;
        if (valid !== 1'b0 || addr !== 6'd0 || got_q.size() != 0) begin
            errors++; $display("FAIL mid_idle: valid=%b addr=%0d issues=%0d, required 0/0/0", valid, addr, got_q.size());
        end
        ready = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        checks++;
        if (valid !== 1'b1 || {opcode, operand} !== 16'h33CD) begin
            errors++; $display("FAIL mid_restart: valid=%b pair=%h, required 1/33cd", valid, {opcode, operand});
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] = 8'($urandom);
                if (i[0] && $urandom_range(0, 7) == 0) mem[i] = 8'h00;
            end
            mem[2 * $urandom_range(0, 31) + 1] = 8'h00;
            do_reset;
            model_walk(6'd0);
            start = 1'b1; tick; start = 1'b0;
            run_to_halt(1'b1);
            checks++;
            if (got_q.size() != exp_q.size() || halted !== 1'b1 || addr !== exp_halt) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d pairs halted=%b addr=%0d, required %0d/1/%0d",
                         it, got_q.size(), halted, addr, exp_q.size(), exp_halt);
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rand%0d_pair%0d: got %h required %h", it, i, got_q[i], exp_q[i]);
                    end
                end
            end
        end
        load_image;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_jump_fetch;
        test_jump_issue;
        test_halt_resume;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 8-bit processor. It drives the 6-bit instruction-memory address as {program counter, instruction counter} and reads each instruction as an even-address operand byte followed by an odd-address opcode byte. It holds the assembled pair in output registers and hands it to the decoder with a valid/ready handshake. It also handles start, jump redirect and halt-on-opcode.

## Interface
- ADDR_W, 6, instruction-memory address width; upper PC_W bits are PC, rest are instruction counter
- PC_W, 3, program-counter width
- DATA_W, 8, memory word / operand / opcode width
- HALT_OPCODE, 8'h00, opcode that stops fetching (matches memory default for unmapped addresses)
- fetch_ctrl_clk  in  1  single clock, rising edge
- fetch_ctrl_rst  in  1  asynchronous, active-high reset
- fetch_ctrl_start  in  1  begin/resume fetching; honoured only in IDLE or HALT
- fetch_ctrl_jump  in  1  redirect request
- fetch_ctrl_jump_addr  in  ADDR_W  jump target; bit 0 ignored (forced even)
- fetch_ctrl_instr_mem_addr  out  ADDR_W  address to instruction memory, registered
- fetch_ctrl_instr_mem_data  in  DATA_W  combinational read data for current address
- fetch_ctrl_operand  out  DATA_W  captured even-address byte
- fetch_ctrl_opcode  out  DATA_W  captured odd-address byte
- fetch_ctrl_valid  out  1  operand/opcode pair presented to decoder
- fetch_ctrl_ready  in  1  decoder accepts pair when high with valid
- fetch_ctrl_halted  out  1  high while in HALT

## Operation
- States: IDLE, FETCH_DATA, FETCH_OPCODE, ISSUE, HALT.
- Reset (asynchronous): state IDLE. Address, operand and opcode are 0. valid and halted are 0.
- IDLE: when start is high, go to FETCH_DATA. The address stays at its current value, which is 0 after reset.
- FETCH_DATA: capture mem_data into operand, then address +1 and go to FETCH_OPCODE.
- FETCH_OPCODE: capture mem_data into opcode, then address +1.
  - If the captured byte equals HALT_OPCODE, go to HALT. The halt pair is not issued.
  - Otherwise go to ISSUE.
- ISSUE: valid=1. operand and opcode are held stable until valid&ready. On valid&ready, go to FETCH_DATA.
- HALT: halted=1 and the address is held at the byte after the halt opcode. start resumes fetching from there; go to FETCH_DATA.
- Address arithmetic: a single ADDR_W-bit increment. An instruction-counter carry propagates into the PC. 63 wraps to 0 with no flag.
- Jump, when in FETCH_DATA, FETCH_OPCODE or ISSUE:
  - Highest priority.
  - Next address is {jump_addr[ADDR_W-1:1],1'b0} and next state is FETCH_DATA.
  - Any partially fetched pair is discarded and valid drops the next cycle.
  - If jump and valid&ready occur in the same cycle, the pair counts as consumed and the jump target still wins.
- jump is ignored in IDLE and HALT. start is ignored in the other states.
- Reset mid-fetch or mid-issue aborts immediately. valid drops asynchronously.

## Timing
- Memory is read combinationally. The address is a register output, and data is sampled at the end of the same cycle.
- Minimum 3 cycles per instruction (FETCH_DATA, FETCH_OPCODE, ISSUE with ready=1).
- Back-pressure stalls only in ISSUE; no fetch is performed while stalled.
- start sampled at edge N gives FETCH_DATA in cycle N+1 and valid in cycle N+3.
- jump sampled at edge N puts the target on the address bus in cycle N+1. The first valid after a jump is in cycle N+3.
- halted rises one cycle after the halt opcode is fetched.

## Structure
- Shared package processor_pkg: the fetch_state_t enum (IDLE, FETCH_DATA, FETCH_OPCODE, ISSUE, HALT), the HALT_OPCODE constant, and the ADDR_W/PC_W/DATA_W constants shared with instruction memory and the decoder.
- Single module. The address counter stays inline; no sub-module is warranted.

## Test plan
Memory image for all cases: 0:CD 1:33 2:63 3:30 4:FF 5:04 6:FF 7:C0, all other addresses 00.

- Reset then start with ready=1: pairs (opcode, operand) are issued as (33,CD), (30,63), (04,FF), (C0,FF), each 3 cycles apart with the first valid at start+3. The fetch at 8/9 reads 00, so halted=1 with address 10 and no fifth valid.
- Hold ready=0 for 5 cycles at the first ISSUE: valid stays high and (33,CD) is stable. The address bus stays at 2 until ready rises.
- Jump to address 5 during the FETCH_OPCODE of the first pair: target forced to 4. The partial pair is dropped, and the next issue is (04,FF).
- jump to 4 in the same cycle as a valid&ready of (33,CD): the pair is consumed once and the next issued pair is (04,FF).
- While halted, pulse start after jumping memory content to nonzero at 10/11: fetching resumes at 10. Separately, a jump while halted is ignored.
- Assert reset during ISSUE of (30,63): valid, outputs and address go to 0 immediately. The state is IDLE and no issue occurs until start.
